// File: rtl/xpb_accum_if.sv
// xpb_accum_if: term-in / result-out handshake bundle for the xpb accumulator.
// Ports: in_valid/in_ready/in_data/in_last carry xpb terms toward the accumulator;
//        out_valid/out_ready/out_data carry the resolved WIDTH+GUARD-bit sum back out.
interface xpb_accum_if #(
  parameter int WIDTH = 1024,
  parameter int GUARD = 8
);
  localparam int W = WIDTH + GUARD;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;

  // Producer / consumer side (LUT bank feeding terms, result sink).
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/xpb_accum.sv
// xpb_accum: sums a base value and a stream of xpb terms (carry-save, 1 term/cycle),
//   then resolves the carry-save pair limb-serially into one binary sum.
// Ports: clk, rst_n (sync, active-low), start_i/base_i (begin + initial addend),
//   term_ovf (sticky: too many terms for the guard bits), bus (slave side of xpb_accum_if).
module xpb_accum #(
  parameter int WIDTH = 1024,
  parameter int GUARD = 8,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  output logic             term_ovf,
  xpb_accum_if.slave       bus
);

  localparam int W    = WIDTH + GUARD;
  localparam int NL   = (W + LIMB - 1) / LIMB;
  localparam int LI_W = (NL > 1) ? $clog2(NL) : 1;

  // Term count at which one more term can exceed what the guard bits hold.
  localparam logic [GUARD:0] CNT_LIMIT = (GUARD+1)'((1 << GUARD) - 1);
  localparam logic [GUARD:0] CNT_SAT   = '1;
  localparam logic [LI_W-1:0] LI_LAST  = LI_W'(NL - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_nxt;

  logic [W-1:0]    s_q;
  logic [W-1:0]    c_q;
  logic [W-1:0]    r_q;
  logic [GUARD:0]  cnt_q;
  logic [LI_W-1:0] li_q;
  logic            rc_q;
  logic            ovf_q;

  logic            acc_hs;
  logic [W-1:0]    d_ext;
  logic [W-1:0]    s_nxt;
  logic [W-1:0]    c_nxt;
  logic [31:0]     sh;
  logic [LIMB:0]   limb_sum;
  logic [W-1:0]    r_nxt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (li_q == LI_LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Carry-save step: a full-adder per bit column, carries shifted up one place.
  // The carry out of the top column falls off, which is the mod 2^W behaviour.
  // ---------------------------------------------------------------------------
  assign acc_hs = (state == ACCUM) && bus.in_valid;
  assign d_ext  = W'(bus.in_data);
  assign s_nxt  = s_q ^ c_q ^ d_ext;
  assign c_nxt  = ((s_q & c_q) | (s_q & d_ext) | (c_q & d_ext)) << 1;

  // ---------------------------------------------------------------------------
  // Limb-serial resolve. Limbs are taken by shifting the W-bit operands down,
  // so the narrow top limb is naturally zero-padded. Any sum bits that land
  // above W when written back are shifted out, discarding the top carry.
  // ---------------------------------------------------------------------------
  assign sh       = 32'(li_q) * 32'(LIMB);
  assign limb_sum = {1'b0, LIMB'(s_q >> sh)}
                  + {1'b0, LIMB'(c_q >> sh)}
                  + {{LIMB{1'b0}}, rc_q};
  assign r_nxt    = (r_q & ~(W'({LIMB{1'b1}}) << sh))
                  | (W'(limb_sum[LIMB-1:0]) << sh);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      c_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      li_q  <= '0;
      rc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            s_q   <= W'(base_i);
            c_q   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (acc_hs) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
            // Sticky: once past the limit the counter only grows or saturates.
            if (cnt_q >= CNT_LIMIT) ovf_q <= 1'b1;
            if (bus.in_last) begin
              li_q <= '0;
              rc_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_q  <= r_nxt;
          rc_q <= limb_sum[LIMB];
          li_q <= (li_q == LI_LAST) ? '0 : li_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data = r_q;
  assign term_ovf     = ovf_q;

endmodule
